ain_layer_sched: RTL and testbench

Sequencer for one fully-connected layer built on the AIN neuron datapath (signed 4-bit inputs and weights, multiply, sum, ReLU, 5-bit result). The block time-multiplexes a single 4x4 signed multiplier and accumulator across `N_NEU` neurons of `N_IN` inputs each. It loads an input vector over a valid/ready stream and fetches weights from an external synchronous weight ROM. It emits one ReLU-activated result per neuron on a valid/ready output stream.

---
 rtl/ain_layer_sched.sv | 154 +++++++++++++++
 tb/tb_ain_layer_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ain_layer_sched.sv
// Layer sequencer for the AIN neuron datapath: loads an input vector, then
// time-shares one 4x4 signed MAC across N_NEU neurons and streams ReLU results.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting N_IN input samples into x_buf
// MAC   | step k=0..N_IN: fetch weight k, accumulate x_buf[k-1]*w_data
// OUT   | presenting result of neuron n until y_ready
module ain_layer_sched #(
    parameter int N_IN  = 2,
    parameter int N_NEU = 4,
    parameter int ACC_W = 8 + $clog2(N_IN),
    localparam int AW = $clog2(N_IN * N_NEU),
    localparam int NW = (N_NEU > 1) ? $clog2(N_NEU) : 1,
    localparam int KW = $clog2(N_IN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic          x_valid,
    output logic          x_ready,
    input  logic [3:0]    x_data,
    output logic [AW-1:0] w_addr,
    input  logic [3:0]    w_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [4:0]    y_data,
    output logic [NW-1:0] y_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [KW-1:0]            k;
    logic [NW-1:0]            n;
    logic signed [ACC_W-1:0]  acc;
    logic                     done_q;
    logic [AW-1:0]            w_addr_q;
    logic [3:0]               x_buf [N_IN];
    logic [3:0]               x_sel;
    logic [KW-1:0]            k_m1;
    logic [7:0]               prod;
    logic                     mac_fetch;
    logic                     last_load;
    logic                     last_step;
    logic                     last_neu;

    assign last_load = (k == KW'(N_IN - 1));
    assign last_step = (k == KW'(N_IN));
    assign last_neu  = (n == NW'(N_NEU - 1));
    assign mac_fetch = (state == S_MAC) && (k < KW'(N_IN));
    assign k_m1      = k - 1'b1;

    always_comb begin
        x_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (k_m1 == KW'(i)) x_sel = x_buf[i];
        end
    end

    // Low 8 bits of the unsigned product of sign-extended operands equal the signed product.
    assign prod = {{4{x_sel[3]}}, x_sel} * {{4{w_data[3]}}, w_data};

    // Address is combinational so the synchronous ROM returns the weight on the next step.
    assign w_addr = mac_fetch ? (AW'(n) * AW'(N_IN) + AW'(k)) : w_addr_q;

    always_comb begin
        state_nxt = state;
        x_ready   = 1'b0;
        y_valid   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                x_ready = 1'b1;
                if (x_valid && last_load) state_nxt = S_MAC;
            end
            S_MAC: begin
                if (last_step) state_nxt = S_OUT;
            end
            S_OUT: begin
                y_valid = 1'b1;
                if (y_ready) state_nxt = last_neu ? S_IDLE : S_MAC;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= '0;
            n        <= '0;
            acc      <= '0;
            done_q   <= 1'b0;
            w_addr_q <= '0;
        end else begin
            state    <= state_nxt;
            done_q   <= 1'b0;
            w_addr_q <= w_addr;
            case (state)
                S_IDLE: begin
                    if (start) k <= '0;
                end
                S_LOAD: begin
                    if (x_valid) begin
                        if (last_load) begin
                            k <= '0;
                            n <= '0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (k == '0) acc <= '0;
                    else         acc <= acc + {{(ACC_W-8){prod[7]}}, prod};
                    k <= last_step ? '0 : k + 1'b1;
                end
                S_OUT: begin
                    if (y_ready) begin
                        if (last_neu) done_q <= 1'b1;
                        else          n <= n + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == S_LOAD && x_valid) begin
            for (int i = 0; i < N_IN; i++) begin
                if (k == KW'(i)) x_buf[i] <= x_data;
            end
        end
    end

    // ReLU, then keep the low five bits exactly as the neuron datapath does.
    assign y_data = (!acc[ACC_W-1] && (acc != '0)) ? acc[4:0] : 5'd0;
    assign y_idx  = n;
    assign busy   = (state != S_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_ain_layer_sched.sv
// Directed bench for ain_layer_sched at default parameters with a synchronous
// weight ROM model; each scenario task checks its own expectations.
module tb_ain_layer_sched;

    logic       clk = 1'b0;
    logic       rst, start, x_valid, y_ready;
    logic       busy, done, x_ready, y_valid;
    logic [3:0] x_data, w_data;
    logic [2:0] w_addr;
    logic [4:0] y_data;
    logic [1:0] y_idx;
    logic [3:0] rom [8];

    int tests = 0;
    int fails = 0;

    int res_idx [8];
    int res_data [8];
    int res_cyc [8];
    int nres, ndone, first_y, first_mac, acc2, busy_at_done, busy_end;
    int exp_b [4] = '{9, 0, 28, 0};
    int exp_t [4] = '{0, 8, 0, 8};

    ain_layer_sched dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .w_addr(w_addr), .w_data(w_data),
        .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_idx(y_idx)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) w_data <= rom[w_addr];

    // Runs one pass with y_ready=1; records observations only.
    task automatic drive_pass(input logic [3:0] xa, input logic [3:0] xb,
                              input logic [3:0] vpat, input int sp1, input int sp2);
        int samp = 0;
        int done_cyc = -1;
        nres = 0; ndone = 0; first_y = -1; first_mac = -1; acc2 = -1;
        busy_at_done = -1; busy_end = -1;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b0; y_ready = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (y_valid && first_y < 0) first_y = c;
            if (y_valid && y_ready && nres < 8) begin
                res_idx[nres] = y_idx; res_data[nres] = y_data; res_cyc[nres] = c; nres++;
            end
            if (busy && !x_ready && !y_valid && first_mac < 0) first_mac = c;
            if (done) begin ndone++; done_cyc = c; busy_at_done = busy; end
            start = (c == sp1 || c == sp2);
            if (x_ready && samp < 2) begin
                x_valid = (c <= 4) ? vpat[c-1] : 1'b1;
                x_data  = (samp == 0) ? xa : xb;
                if (x_valid) begin samp++; if (samp == 2) acc2 = c; end
            end else begin
                x_valid = 1'b0;
            end
            if (done_cyc > 0 && c == done_cyc + 2) begin busy_end = busy; break; end
        end
        start = 1'b0; x_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = 4'd0; y_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        tests++; if (busy !== 1'b0)    begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (done !== 1'b0)    begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (x_ready !== 1'b0) begin fails++; $display("FAIL reset_x_ready got %b exp 0", x_ready); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid got %b exp 0", y_valid); end
        tests++; if (y_data !== 5'd0)  begin fails++; $display("FAIL reset_y_data got %0d exp 0", y_data); end
        tests++; if (y_idx !== 2'd0)   begin fails++; $display("FAIL reset_y_idx got %0d exp 0", y_idx); end
        tests++; if (w_addr !== 3'd0)  begin fails++; $display("FAIL reset_w_addr got %0d exp 0", w_addr); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        drive_pass(4'd3, 4'd1, 4'b1111, -1, -1);
        tests++; if (first_y != 6)   begin fails++; $display("FAIL basic_first_y got %0d exp 6", first_y); end
        tests++; if (first_mac != 3) begin fails++; $display("FAIL basic_first_mac got %0d exp 3", first_mac); end
        tests++; if (nres != 4)      begin fails++; $display("FAIL basic_nres got %0d exp 4", nres); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (res_idx[i] != i) begin fails++; $display("FAIL basic_idx%0d got %0d exp %0d", i, res_idx[i], i); end
            tests++; if (res_data[i] != exp_b[i]) begin fails++; $display("FAIL basic_data%0d got %0d exp %0d", i, res_data[i], exp_b[i]); end
        end
        tests++; if (res_cyc[3] - res_cyc[2] != 4) begin fails++; $display("FAIL basic_neuron_gap got %0d exp 4", res_cyc[3] - res_cyc[2]); end
        tests++; if (ndone != 1)        begin fails++; $display("FAIL basic_ndone got %0d exp 1", ndone); end
        tests++; if (busy_at_done != 0) begin fails++; $display("FAIL basic_busy_at_done got %0d exp 0", busy_at_done); end
        tests++; if (busy_end != 0)     begin fails++; $display("FAIL basic_busy_end got %0d exp 0", busy_end); end
    endtask

    task automatic test_truncation;
        rom[0] = 4'h8; rom[1] = 4'h8;
        drive_pass(4'h8, 4'h8, 4'b1111, -1, -1);
        tests++; if (nres != 4) begin fails++; $display("FAIL trunc_nres got %0d exp 4", nres); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (res_data[i] != exp_t[i]) begin fails++; $display("FAIL trunc_data%0d got %0d exp %0d", i, res_data[i], exp_t[i]); end
        end
        rom[0] = 4'd2; rom[1] = 4'd3;
    endtask

    task automatic test_input_stall;
        drive_pass(4'd3, 4'd1, 4'b1001, -1, -1);
        tests++; if (acc2 != 4)      begin fails++; $display("FAIL stall_second_accept got %0d exp 4", acc2); end
        tests++; if (first_mac != 5) begin fails++; $display("FAIL stall_first_mac got %0d exp 5", first_mac); end
        tests++; if (first_y != 8)   begin fails++; $display("FAIL stall_first_y got %0d exp 8", first_y); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (res_data[i] != exp_b[i]) begin fails++; $display("FAIL stall_data%0d got %0d exp %0d", i, res_data[i], exp_b[i]); end
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL stall_ndone got %0d exp 1", ndone); end
    endtask

    task automatic test_backpressure;
        int samp = 0;
        int st = -1;
        int hs = -1;
        int v3 = -1;
        int d3 = -1;
        int i3 = -1;
        int seen_done = 0;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = 4'd3; y_ready = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (x_ready) begin x_data = (samp == 0) ? 4'd3 : 4'd1; samp++; end
            if (st < 0 && y_valid && y_idx == 2'd2) st = c;
            if (st > 0 && c < st + 5) begin
                tests++;
                if (y_valid !== 1'b1 || y_idx !== 2'd2 || y_data !== 5'd28 || w_addr !== 3'd5) begin
                    fails++;
                    $display("FAIL bp_hold c=%0d got v=%b idx=%0d data=%0d addr=%0d exp v=1 idx=2 data=28 addr=5", c, y_valid, y_idx, y_data, w_addr);
                end
                y_ready = 1'b0;
            end else begin
                y_ready = 1'b1;
            end
            if (st > 0 && c == st + 5) hs = c;
            if (hs > 0 && c > hs && y_valid && v3 < 0) begin v3 = c; d3 = y_data; i3 = y_idx; end
            if (done) begin seen_done = 1; break; end
        end
        x_valid = 1'b0;
        tests++; if (st != 14)     begin fails++; $display("FAIL bp_idx2_cycle got %0d exp 14", st); end
        tests++; if (v3 - hs != 4) begin fails++; $display("FAIL bp_idx3_gap got %0d exp 4", v3 - hs); end
        tests++; if (i3 != 3)      begin fails++; $display("FAIL bp_idx3 got %0d exp 3", i3); end
        tests++; if (d3 != 0)      begin fails++; $display("FAIL bp_data3 got %0d exp 0", d3); end
        tests++; if (seen_done != 1) begin fails++; $display("FAIL bp_done got %0d exp 1", seen_done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = 4'd3; y_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 2) x_data = 4'd1;
            if (c == 8) begin
                tests++; if (!(busy && !x_ready && !y_valid && y_idx == 2'd1)) begin
                    fails++; $display("FAIL rstmid_in_mac got busy=%b xr=%b yv=%b idx=%0d exp 1 0 0 1", busy, x_ready, y_valid, y_idx);
                end
                rst = 1'b1;
            end
            if (c == 9) begin
                tests++; if (busy !== 1'b0 || done !== 1'b0 || x_ready !== 1'b0 || y_valid !== 1'b0) begin
                    fails++; $display("FAIL rstmid_ctrl got busy=%b done=%b xr=%b yv=%b exp all 0", busy, done, x_ready, y_valid);
                end
                tests++; if (y_data !== 5'd0 || y_idx !== 2'd0 || w_addr !== 3'd0) begin
                    fails++; $display("FAIL rstmid_data got data=%0d idx=%0d addr=%0d exp 0 0 0", y_data, y_idx, w_addr);
                end
                rst = 1'b0;
            end
        end
        x_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || y_valid || busy) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad); end
        drive_pass(4'd3, 4'd1, 4'b1111, -1, -1);
        tests++; if (nres != 4 || ndone != 1) begin fails++; $display("FAIL rstmid_rerun got nres=%0d ndone=%0d exp 4 1", nres, ndone); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (res_data[i] != exp_b[i]) begin fails++; $display("FAIL rstmid_data%0d got %0d exp %0d", i, res_data[i], exp_b[i]); end
        end
    endtask

    task automatic test_start_busy;
        drive_pass(4'd3, 4'd1, 4'b1111, 1, 6);
        tests++; if (first_y != 6) begin fails++; $display("FAIL sbusy_first_y got %0d exp 6", first_y); end
        tests++; if (ndone != 1)   begin fails++; $display("FAIL sbusy_ndone got %0d exp 1", ndone); end
        tests++; if (busy_end != 0) begin fails++; $display("FAIL sbusy_busy_end got %0d exp 0", busy_end); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (res_data[i] != exp_b[i] || res_idx[i] != i) begin
                fails++; $display("FAIL sbusy_res%0d got idx=%0d data=%0d exp idx=%0d data=%0d", i, res_idx[i], res_data[i], i, exp_b[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int d = -1;
        int b_done = -1;
        int b_after = -1;
        int xr_after = -1;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = 4'd3; y_ready = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done && d < 0) begin d = c; b_done = busy; end
            if (d > 0 && c == d + 1) begin b_after = busy; xr_after = x_ready; break; end
        end
        tests++; if (d != 19)      begin fails++; $display("FAIL b2b_done_cycle got %0d exp 19", d); end
        tests++; if (b_done != 0)  begin fails++; $display("FAIL b2b_busy_at_done got %0d exp 0", b_done); end
        tests++; if (b_after != 1) begin fails++; $display("FAIL b2b_relaunch_busy got %0d exp 1", b_after); end
        tests++; if (xr_after != 1) begin fails++; $display("FAIL b2b_relaunch_load got %0d exp 1", xr_after); end
        start = 1'b0; x_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rom[0] = 4'd2;  rom[1] = 4'd3;
        rom[2] = 4'hE;  rom[3] = 4'hD;
        rom[4] = 4'd7;  rom[5] = 4'd7;
        rom[6] = 4'h8;  rom[7] = 4'd7;
        test_reset;
        test_basic;
        test_truncation;
        test_input_stall;
        test_backpressure;
        test_start_busy;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
